// File: rtl/link_tx_framer.sv
// Half-duplex transmit framer for one OSERDES lane: preamble, SOF, data, checksum, EOF,
// then a fixed line-release gap so the far end can drive.
module link_tx_framer #(
  parameter int          PREAMBLE_LEN = 4,
  parameter int          GAP_LEN      = 8,
  parameter logic [7:0]  SOF_BYTE     = 8'hD5,
  parameter logic [7:0]  EOF_BYTE     = 8'h5D,
  parameter logic [7:0]  FILL_BYTE    = 8'h3C
) (
  input  logic        clk160,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic [15:0] fill_count
);

  typedef enum logic [2:0] {IDLE, PRE, SOF, DATA, FILL, CHK, EOF, GAP} state_t;

  localparam logic [7:0] PRE_INIT = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GAP_INIT = 8'(GAP_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [15:0] frames_q, frames_d;
  logic [15:0] fills_q, fills_d;
  logic        fetch;
  logic [7:0]  cur_byte;

  assign cur_byte = word_q[{idx_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    last_d  = last_q;
    chk_d   = chk_q;
    fetch   = 1'b0;
    case (state_q)
      IDLE: if (enable && s_tvalid) begin
        state_d = PRE;
        cnt_d   = PRE_INIT;
      end
      PRE: if (cnt_q == 8'd0) state_d = SOF;
           else cnt_d = cnt_q - 8'd1;
      SOF: begin
        chk_d = 8'd0;
        fetch = 1'b1;
      end
      DATA: begin
        chk_d = chk_q + cur_byte;
        if (idx_q != 2'd0) idx_d = idx_q - 2'd1;
        else if (last_q)   state_d = CHK;
        else               fetch = 1'b1;
      end
      FILL: fetch = 1'b1;
      CHK:  state_d = EOF;
      EOF: begin
        state_d = GAP;
        cnt_d   = GAP_INIT;
      end
      GAP: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
           else if (enable && s_tvalid) begin
             state_d = PRE;
             cnt_d   = PRE_INIT;
           end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Fetch slot: load the next word, or pad the line while the source underruns.
    if (fetch) begin
      if (s_tvalid) begin
        word_d  = s_tdata;
        last_d  = s_tlast;
        idx_d   = 2'd3;
        state_d = DATA;
      end else begin
        state_d = FILL;
      end
    end
  end

  // Outputs are registered, so they are computed from the state being entered.
  always_comb begin
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b1;
    frames_d   = frames_q;
    fills_d    = fills_q;
    case (state_d)
      PRE:  tx_data_d = 8'h55;
      SOF:  tx_data_d = SOF_BYTE;
      DATA: tx_data_d = word_d[{idx_d, 3'b000} +: 8];
      FILL: begin
        tx_data_d = FILL_BYTE;
        if (fills_q != 16'hFFFF) fills_d = fills_q + 16'd1;
      end
      CHK:  tx_data_d = chk_d;
      EOF: begin
        tx_data_d = EOF_BYTE;
        frames_d  = frames_q + 16'd1;
      end
      default: tx_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= 2'd0;
      word_q     <= 32'd0;
      last_q     <= 1'b0;
      chk_q      <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      frames_q   <= 16'd0;
      fills_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      last_q     <= last_d;
      chk_q      <= chk_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      frames_q   <= frames_d;
      fills_q    <= fills_d;
    end
  end

  assign s_tready    = fetch;
  assign busy        = (state_q != IDLE);
  assign tx_tdata    = tx_data_q;
  assign tx_tvalid   = tx_valid_q;
  assign frames_sent = frames_q;
  assign fill_count  = fills_q;

endmodule

// File: tb/tb_link_tx_framer.sv
// Scoreboard bench for link_tx_framer: expected line bytes are queued as packets are
// offered and popped by a monitor whenever the driver enable is high.
module tb_link_tx_framer;

  logic        clk160 = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        busy;
  logic [15:0] frames_sent;
  logic [15:0] fill_count;

  link_tx_framer dut (
    .clk160(clk160), .rst(rst), .enable(enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .busy(busy),
    .frames_sent(frames_sent), .fill_count(fill_count)
  );

  always #5 clk160 = ~clk160;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_chk;
  int rdy_cycles = 0;
  int low_run    = 0;
  int last_gap   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk160) begin
    if (s_tready) rdy_cycles++;
    if (tx_tvalid) begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
      check("sb_has_entry", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("tx_byte", tx_tdata, exp_q.pop_front());
    end else begin
      low_run++;
    end
  end

  task automatic push_head();
    repeat (4) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    m_chk = 8'h00;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      exp_q.push_back(w[i*8 +: 8]);
      m_chk = m_chk + w[i*8 +: 8];
    end
  endtask

  task automatic push_tail();
    exp_q.push_back(m_chk);
    exp_q.push_back(8'h5D);
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk160);
    while (!s_tready && n < 300) begin @(negedge clk160); n++; end
    if (!s_tready) check("accept_timeout", 32'(s_tready), 1);
    @(posedge clk160); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic skip_slots(input int k);
    repeat (k) begin
      int n = 0;
      @(negedge clk160);
      while (!s_tready && n < 50) begin @(negedge clk160); n++; end
      if (!s_tready) check("slot_timeout", 32'(s_tready), 1);
      @(posedge clk160); #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk160);
    while (busy && n < 500) begin @(negedge clk160); n++; end
    if (busy) check("idle_timeout", 32'(busy), 0);
    check("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'd0;
    repeat (3) @(negedge clk160);
    check("rst_tvalid", 32'(tx_tvalid), 0);
    check("rst_tdata", tx_tdata, 0);
    check("rst_tready", 32'(s_tready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frames", frames_sent, 0);
    check("rst_fills", fill_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk160);

    // single word frame
    rdy_cycles = 0;
    push_head(); push_word(32'h11223344); push_tail();
    check("t1_model_chk", m_chk, 8'hAA);
    send_word(32'h11223344, 1'b1);
    wait_idle();
    check("t1_frames", frames_sent, 1);
    check("t1_ready_cycles", rdy_cycles, 1);
    check("t1_gap", low_run >= 8 ? 32'd1 : 32'd0, 1);

    // two words, continuous
    push_head(); push_word(32'h01020304); push_word(32'hFFFFFFFF); push_tail();
    send_word(32'h01020304, 1'b0);
    send_word(32'hFFFFFFFF, 1'b1);
    wait_idle();
    check("t2_frames", frames_sent, 2);
    check("t2_fills", fill_count, 0);

    // two words with the second withheld for two fetch slots
    push_head(); push_word(32'h01020304);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h3C);
    push_word(32'hFFFFFFFF); push_tail();
    send_word(32'h01020304, 1'b0);
    skip_slots(2);
    send_word(32'hFFFFFFFF, 1'b1);
    wait_idle();
    check("t3_fills", fill_count, 2);
    check("t3_frames", frames_sent, 3);

    // back-to-back frames
    push_head(); push_word(32'hCAFEF00D); push_tail();
    push_head(); push_word(32'h0BADBEEF); push_tail();
    send_word(32'hCAFEF00D, 1'b1);
    send_word(32'h0BADBEEF, 1'b1);
    wait_idle();
    check("t4_gap", last_gap, 8);
    check("t4_frames", frames_sent, 5);

    // enable low holds the framer idle
    enable = 1'b0; s_tdata = 32'h12345678; s_tlast = 1'b1; s_tvalid = 1'b1;
    repeat (5) begin
      @(negedge clk160);
      check("t5_idle_tvalid", 32'(tx_tvalid), 0);
      check("t5_idle_tready", 32'(s_tready), 0);
      check("t5_idle_busy", 32'(busy), 0);
    end
    push_head(); push_word(32'h12345678); push_word(32'h9ABCDEF0); push_tail();
    enable = 1'b1;
    send_word(32'h12345678, 1'b0);
    enable = 1'b0;
    send_word(32'h9ABCDEF0, 1'b1);
    wait_idle();
    check("t5_frames", frames_sent, 6);
    enable = 1'b1;

    // reset in the middle of DATA
    push_head(); push_word(32'hA1B2C3D4); push_tail();
    send_word(32'hA1B2C3D4, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_tvalid", 32'(tx_tvalid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_frames", frames_sent, 0);
    check("t6_fills", fill_count, 0);
    exp_q.delete();
    @(negedge clk160); rst = 1'b0;
    repeat (2) @(negedge clk160);
    push_head(); push_word(32'h0F0F0F0F); push_tail();
    check("t6_model_chk", m_chk, 8'h3C);
    send_word(32'h0F0F0F0F, 1'b1);
    wait_idle();
    check("t6_frames_after", frames_sent, 1);

    repeat (3) @(negedge clk160);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
